// File: rtl/dbg_loader_pkg.sv
// Shared types and constants for the debug program loader.
//   loader_state_t : loader FSM states
//   dbg_word_t     : one buffered (address, instruction) pair
//   WR_COUNT_W     : width of the saturating write counter
package dbg_loader_pkg;

  localparam int unsigned DBG_XLEN   = 32;
  localparam int unsigned WR_COUNT_W = 16;

  typedef enum logic [2:0] {
    LOAD_IDLE,
    SETUP,
    WRITE,
    RELEASE,
    RUN
  } loader_state_t;

  typedef struct packed {
    logic [DBG_XLEN-1:0] addr;
    logic [DBG_XLEN-1:0] instr;
  } dbg_word_t;

endpackage

// File: rtl/dbg_word_fifo.sv
// Synchronous FIFO of dbg_word_t with first-word fall-through read data.
// Ports:
//   clk, rst_n       : clock, async active-low reset (clears pointers)
//   i_push, i_data   : write request and word (ignored when full)
//   i_pop            : consume head (ignored when empty)
//   o_data           : current head word
//   o_full, o_empty  : status
// Pointers carry one extra wrap bit so full and empty stay distinct at wrap.
module dbg_word_fifo
  import dbg_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  dbg_word_t i_data,
  input  logic      i_pop,
  output dbg_word_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  dbg_word_t   r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop  && !o_empty) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/dbg_program_loader.sv
// Boot-time program loader: buffers host (address, instruction) words and
// writes them into the core's debug instruction port, holding the core in
// reset until the host issues start; halt returns to loading.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   s_valid/s_ready            : host word handshake
//   s_addr, s_instr            : host word (address must be 4-byte aligned)
//   start, halt                : release / re-halt pulses
//   dbg_wr_en/addr/instr       : debug write port toward the core
//   core_rst, running          : core reset (active-high) and run status
//   err_align                  : sticky misaligned-word flag
//   wr_count                   : saturating count of words written
//   cksum                      : running instruction sum (DBG_LOADER_CKSUM_EN only)
// Optional feature macro: DBG_LOADER_CKSUM_EN.
module dbg_program_loader
  import dbg_loader_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned RELEASE_DLY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [XLEN-1:0]       s_addr,
  input  logic [XLEN-1:0]       s_instr,
  input  logic                  start,
  input  logic                  halt,
  output logic                  dbg_wr_en,
  output logic [XLEN-1:0]       dbg_addr,
  output logic [XLEN-1:0]       dbg_instr,
  output logic                  core_rst,
  output logic                  running,
  output logic                  err_align,
  output logic [WR_COUNT_W-1:0] wr_count
`ifdef DBG_LOADER_CKSUM_EN
  ,
  output logic [XLEN-1:0]       cksum
`endif
);

  localparam int unsigned CNT_MAX = (SETUP_CYC > RELEASE_DLY) ? SETUP_CYC : RELEASE_DLY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  loader_state_t         r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_start_pend;
  logic                  r_wr_en;
  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_instr;
  logic                  r_core_rst;
  logic                  r_running;
  logic                  r_err_align;
  logic [WR_COUNT_W-1:0] r_wr_count;
`ifdef DBG_LOADER_CKSUM_EN
  logic [XLEN-1:0]       r_cksum;
`endif

  logic      w_full;
  logic      w_empty;
  logic      w_accept;
  logic      w_aligned;
  logic      w_bypass;
  logic      w_push;
  logic      w_pop;
  dbg_word_t w_in;
  dbg_word_t w_head;

  assign s_ready   = !w_full && (r_state != RUN);
  assign w_accept  = s_valid && s_ready;
  assign w_aligned = (s_addr[1:0] == 2'b00);
  // An aligned word arriving while idle with an empty FIFO goes straight to
  // the output registers, giving dbg_addr one cycle after acceptance.
  assign w_bypass  = (r_state == LOAD_IDLE) && w_empty && w_accept && w_aligned;
  assign w_push    = w_accept && w_aligned && !w_bypass;
  assign w_pop     = (r_state == LOAD_IDLE) && !w_empty;

  assign w_in.addr  = DBG_XLEN'(s_addr);
  assign w_in.instr = DBG_XLEN'(s_instr);

  dbg_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD_IDLE;
      r_cnt        <= '0;
      r_start_pend <= 1'b0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_instr      <= '0;
      r_core_rst   <= 1'b1;
      r_running    <= 1'b0;
      r_err_align  <= 1'b0;
      r_wr_count   <= '0;
`ifdef DBG_LOADER_CKSUM_EN
      r_cksum      <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept && !w_aligned) r_err_align <= 1'b1;
      if (start && (r_state != RUN)) r_start_pend <= 1'b1;

      case (r_state)
        LOAD_IDLE: begin
          r_cnt <= '0;
          if (!w_empty) begin
            r_addr  <= XLEN'(w_head.addr);
            r_instr <= XLEN'(w_head.instr);
            r_state <= SETUP;
          end else if (w_bypass) begin
            r_addr  <= s_addr;
            r_instr <= s_instr;
            r_state <= SETUP;
          end else if (r_start_pend) begin
            r_state <= RELEASE;
          end
        end
        SETUP: begin
          if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
            r_wr_en <= 1'b1;
            r_state <= WRITE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (r_wr_count != '1) r_wr_count <= r_wr_count + WR_COUNT_W'(1);
`ifdef DBG_LOADER_CKSUM_EN
          r_cksum <= r_cksum + r_instr;
`endif
          r_state <= LOAD_IDLE;
        end
        RELEASE: begin
          if (r_cnt == CNT_W'(RELEASE_DLY - 1)) begin
            r_core_rst <= 1'b0;
            r_running  <= 1'b1;
            r_state    <= RUN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (halt) begin
            r_core_rst   <= 1'b1;
            r_running    <= 1'b0;
            r_wr_count   <= '0;
            r_start_pend <= 1'b0;
`ifdef DBG_LOADER_CKSUM_EN
            r_cksum      <= '0;
`endif
            r_state      <= LOAD_IDLE;
          end
        end
        default: r_state <= LOAD_IDLE;
      endcase
    end
  end

  assign dbg_wr_en = r_wr_en;
  assign dbg_addr  = r_addr;
  assign dbg_instr = r_instr;
  assign core_rst  = r_core_rst;
  assign running   = r_running;
  assign err_align = r_err_align;
  assign wr_count  = r_wr_count;
`ifdef DBG_LOADER_CKSUM_EN
  assign cksum     = r_cksum;
`endif

endmodule
